// File: rtl/mem_responder_pkg.sv
// Shared types and constants for the mem_responder slice: FSM state encoding,
// default geometry/timing, and the saturating counter helper.
package mem_responder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int          DEFAULT_ADDR_BITS = 10;
  localparam int          DEFAULT_LATENCY   = 4;
  localparam logic [15:0] COUNT_MAX         = 16'hFFFF;

  function automatic logic [15:0] satInc(input logic [15:0] value);
    return (value == COUNT_MAX) ? value : value + 16'd1;
  endfunction

endpackage

// File: rtl/mem_responder_array.sv
// Single-port 16-bit word store with synchronous write and synchronous,
// enable-gated read; the read register holds its value while i_re is low.
module mem_responder_array
  import mem_responder_pkg::*;
#(
  parameter int ADDR_BITS = DEFAULT_ADDR_BITS
) (
  input  logic                 i_clk,
  input  logic                 i_we,
  input  logic                 i_re,
  input  logic [ADDR_BITS-1:0] i_addr,
  input  logic [15:0]          i_wdata,
  output logic [15:0]          o_rdata
);

  logic [15:0] r_mem [2**ADDR_BITS];
  logic [15:0] r_rdata;

  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_addr] <= i_wdata;
    end
    if (i_re) begin
      r_rdata <= r_mem[i_addr];
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/mem_responder.sv
// Fixed-latency memory responder: accepts one request at a time, completes it
// LATENCY cycles later with a done pulse, and reports unaligned/conflicting requests.
module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int ADDR_BITS = DEFAULT_ADDR_BITS,
  parameter int LATENCY   = DEFAULT_LATENCY
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_rd,
  input  logic        req_wr,
  input  logic [15:0] addr,
  input  logic [15:0] data_in,
  output logic [15:0] data_out,
  output logic        stall,
  output logic        done,
  output logic        err,
  output logic [15:0] rd_count,
  output logic [15:0] wr_count
);

  localparam bit         DIRECT   = (LATENCY == 1);
  localparam logic [3:0] CNT_LOAD = (LATENCY > 1) ? 4'(LATENCY - 2) : 4'd0;

  state_t                r_state;
  state_t                w_nextState;
  logic [3:0]            r_cnt;
  logic [3:0]            w_nextCnt;

  logic                  r_rd;
  logic                  r_wr;
  logic                  r_misalign;
  logic [ADDR_BITS-1:0]  r_idx;
  logic [15:0]           r_wdata;

  logic                  r_err;
  logic                  r_rdValid;
  logic [15:0]           r_rdCount;
  logic [15:0]           r_wrCount;

  logic                  w_req;
  logic                  w_accept;
  logic                  w_enterDone;
  logic                  w_curRd;
  logic                  w_curWr;
  logic                  w_curMis;
  logic                  w_curErr;
  logic [ADDR_BITS-1:0]  w_curIdx;
  logic [15:0]           w_curData;
  logic                  w_arrWe;
  logic                  w_arrRe;
  logic [15:0]           w_rdata;
  logic                  w_unusedAddr;

  assign w_req    = req_rd | req_wr;
  assign w_accept = w_req & ((r_state == IDLE) | (r_state == DONE));
  assign stall    = w_req & (r_state == BUSY);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_cnt   <= 4'd0;
    end else begin
      r_state <= w_nextState;
      r_cnt   <= w_nextCnt;
    end
  end

  always_comb begin
    w_nextState = r_state;
    w_nextCnt   = r_cnt;
    case (r_state)
      IDLE, DONE: begin
        if (w_accept) begin
          if (DIRECT) begin
            w_nextState = DONE;
          end else begin
            w_nextState = BUSY;
            w_nextCnt   = CNT_LOAD;
          end
        end else begin
          w_nextState = IDLE;
        end
      end
      BUSY: begin
        if (r_cnt == 4'd0) begin
          w_nextState = DONE;
        end else begin
          w_nextCnt = r_cnt - 4'd1;
        end
      end
      default: begin
        w_nextState = IDLE;
        w_nextCnt   = 4'd0;
      end
    endcase
  end

  assign w_enterDone = (w_nextState == DONE);

  // With a one-cycle latency the completing request is the one being accepted
  // on this very edge, so it must come straight from the inputs.
  assign w_curRd   = DIRECT ? req_rd               : r_rd;
  assign w_curWr   = DIRECT ? req_wr               : r_wr;
  assign w_curMis  = DIRECT ? addr[0]              : r_misalign;
  assign w_curIdx  = DIRECT ? addr[ADDR_BITS:1]    : r_idx;
  assign w_curData = DIRECT ? data_in              : r_wdata;
  assign w_curErr  = w_curMis | (w_curRd & w_curWr);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rd       <= 1'b0;
      r_wr       <= 1'b0;
      r_misalign <= 1'b0;
      r_idx      <= '0;
      r_wdata    <= 16'h0000;
    end else if (w_accept) begin
      r_rd       <= req_rd;
      r_wr       <= req_wr;
      r_misalign <= addr[0];
      r_idx      <= addr[ADDR_BITS:1];
      r_wdata    <= data_in;
    end
  end

  // The array has no reset of its own, so its strobes are blocked while rst is low.
  assign w_arrWe = rst & w_enterDone & w_curWr & ~w_curErr;
  assign w_arrRe = rst & w_enterDone & w_curRd & ~w_curErr;

  mem_responder_array #(
    .ADDR_BITS (ADDR_BITS)
  ) u_array (
    .i_clk   (clk),
    .i_we    (w_arrWe),
    .i_re    (w_arrRe),
    .i_addr  (w_curIdx),
    .i_wdata (w_curData),
    .o_rdata (w_rdata)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_err     <= 1'b0;
      r_rdValid <= 1'b0;
      r_rdCount <= 16'h0000;
      r_wrCount <= 16'h0000;
    end else begin
      r_err <= w_enterDone & w_curErr;
      if (w_enterDone && !w_curErr) begin
        if (w_curRd) begin
          r_rdValid <= 1'b1;
          r_rdCount <= satInc(r_rdCount);
        end
        if (w_curWr) begin
          r_wrCount <= satInc(r_wrCount);
        end
      end
    end
  end

  // The array read register is not reset; data_out reads as zero until the
  // first successful read after reset has refreshed it.
  assign data_out = r_rdValid ? w_rdata : 16'h0000;
  assign done     = (r_state == DONE);
  assign err      = r_err;
  assign rd_count = r_rdCount;
  assign wr_count = r_wrCount;

  assign w_unusedAddr = &{1'b0, addr[15:ADDR_BITS+1]};

endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench for mem_responder: a LATENCY=4 instance for the main checks
// and a LATENCY=1 instance for back-to-back completions and count saturation.
module tb_mem_responder;

  typedef struct packed {
    logic        err;
    logic [15:0] data;
    logic [15:0] rdCnt;
    logic [15:0] wrCnt;
  } respT;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst4, reqRd4, reqWr4;
  logic [15:0] addr4, dataIn4, dataOut4, rdCount4, wrCount4;
  logic        stall4, done4, err4;

  logic        rst1, reqRd1, reqWr1;
  logic [15:0] addr1, dataIn1, dataOut1, rdCount1, wrCount1;
  logic        stall1, done1, err1;

  int   compared = 0;
  int   failed   = 0;
  respT q4[$];
  respT q1[$];
  respT e4;
  respT e1;

  mem_responder #(.ADDR_BITS(10), .LATENCY(4)) dut4 (
    .clk(clk), .rst(rst4), .req_rd(reqRd4), .req_wr(reqWr4), .addr(addr4),
    .data_in(dataIn4), .data_out(dataOut4), .stall(stall4), .done(done4),
    .err(err4), .rd_count(rdCount4), .wr_count(wrCount4)
  );

  mem_responder #(.ADDR_BITS(10), .LATENCY(1)) dut1 (
    .clk(clk), .rst(rst1), .req_rd(reqRd1), .req_wr(reqWr1), .addr(addr1),
    .data_in(dataIn1), .data_out(dataOut1), .stall(stall1), .done(done1),
    .err(err1), .rd_count(rdCount1), .wr_count(wrCount1)
  );

  function automatic respT mk(input logic e, input logic [15:0] d,
                              input logic [15:0] r, input logic [15:0] w);
    respT t;
    t.err   = e;
    t.data  = d;
    t.rdCnt = r;
    t.wrCnt = w;
    return t;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input bit onFast, input logic rd, input logic wr,
                               input logic [15:0] a, input logic [15:0] d,
                               input bit hasExp, input respT exp);
    if (hasExp) begin
      if (onFast) q1.push_back(exp);
      else        q4.push_back(exp);
    end
    if (onFast) begin
      reqRd1 = rd; reqWr1 = wr; addr1 = a; dataIn1 = d;
    end else begin
      reqRd4 = rd; reqWr4 = wr; addr4 = a; dataIn4 = d;
    end
    @(posedge clk);
    #1;
    if (onFast) begin
      reqRd1 = 1'b0; reqWr1 = 1'b0;
    end else begin
      reqRd4 = 1'b0; reqWr4 = 1'b0;
    end
  endtask

  task automatic waitDone(input bit onFast, input int budget, output int lat);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (((onFast ? done1 : done4) !== 1'b1) && (lat < budget));
  endtask

  // Scoreboard monitors: every completion pulse pops and checks one expectation.
  always @(negedge clk) begin
    if (rst4 === 1'b1 && done4 === 1'b1) begin
      if (q4.size() == 0) begin
        compared++;
        failed++;
        $display("[TB] FAIL dut4 spurious done: got done=1, expected done=0");
      end else begin
        e4 = q4.pop_front();
        checkOutput("dut4 err",      32'(err4),     32'(e4.err));
        checkOutput("dut4 data_out", 32'(dataOut4), 32'(e4.data));
        checkOutput("dut4 rd_count", 32'(rdCount4), 32'(e4.rdCnt));
        checkOutput("dut4 wr_count", 32'(wrCount4), 32'(e4.wrCnt));
      end
    end
  end

  always @(negedge clk) begin
    if (rst1 === 1'b1 && done1 === 1'b1) begin
      if (q1.size() == 0) begin
        compared++;
        failed++;
        $display("[TB] FAIL dut1 spurious done: got done=1, expected done=0");
      end else begin
        e1 = q1.pop_front();
        checkOutput("dut1 err",      32'(err1),     32'(e1.err));
        checkOutput("dut1 data_out", 32'(dataOut1), 32'(e1.data));
        checkOutput("dut1 rd_count", 32'(rdCount1), 32'(e1.rdCnt));
        checkOutput("dut1 wr_count", 32'(wrCount1), 32'(e1.wrCnt));
      end
    end
  end

  initial begin
    #1500000;
    $display("[TB] FAIL watchdog: got timeout, expected end of run");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int lat;
    int doneSeen;
    rst4 = 1'b0; reqRd4 = 1'b0; reqWr4 = 1'b0; addr4 = 16'h0; dataIn4 = 16'h0;
    rst1 = 1'b0; reqRd1 = 1'b0; reqWr1 = 1'b0; addr1 = 16'h0; dataIn1 = 16'h0;
    repeat (2) @(posedge clk);
    #1;
    reqRd4 = 1'b1;
    addr4  = 16'h0010;
    #1;
    checkOutput("reset data_out", 32'(dataOut4), 32'h0);
    checkOutput("reset done",     32'(done4),    32'h0);
    checkOutput("reset err",      32'(err4),     32'h0);
    checkOutput("reset rd_count", 32'(rdCount4), 32'h0);
    checkOutput("reset wr_count", 32'(wrCount4), 32'h0);
    checkOutput("reset stall",    32'(stall4),   32'h0);
    reqRd4 = 1'b0;
    @(negedge clk);
    rst4 = 1'b1;
    rst1 = 1'b1;

    // Basic write then read-back on the LATENCY=4 instance.
    applyStimulus(0, 1'b0, 1'b1, 16'h0010, 16'h1234, 1, mk(1'b0, 16'h0000, 16'd0, 16'd1));
    waitDone(0, 20, lat);
    checkOutput("dut4 write latency", 32'(lat), 32'd4);
    applyStimulus(0, 1'b1, 1'b0, 16'h0010, 16'h0000, 1, mk(1'b0, 16'h1234, 16'd1, 16'd1));
    waitDone(0, 20, lat);
    checkOutput("dut4 read latency", 32'(lat), 32'd4);

    // A read held through BUSY stalls for three cycles and is taken in DONE.
    applyStimulus(0, 1'b0, 1'b1, 16'h0040, 16'hA5A5, 1, mk(1'b0, 16'h1234, 16'd1, 16'd2));
    reqRd4 = 1'b1; reqWr4 = 1'b0; addr4 = 16'h0040;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      checkOutput($sformatf("dut4 stall cycle %0d", c), 32'(stall4), (c < 4) ? 32'd1 : 32'd0);
    end
    checkOutput("dut4 done cycle 4", 32'(done4), 32'd1);
    q4.push_back(mk(1'b0, 16'hA5A5, 16'd2, 16'd2));
    @(posedge clk);
    #1;
    reqRd4 = 1'b0;
    waitDone(0, 20, lat);
    checkOutput("dut4 held read latency", 32'(lat), 32'd4);

    // Error requests leave array, data_out and counts untouched.
    applyStimulus(0, 1'b1, 1'b0, 16'h0011, 16'h0000, 1, mk(1'b1, 16'hA5A5, 16'd2, 16'd2));
    waitDone(0, 20, lat);
    checkOutput("dut4 unaligned latency", 32'(lat), 32'd4);
    applyStimulus(0, 1'b1, 1'b1, 16'h0040, 16'hFFFF, 1, mk(1'b1, 16'hA5A5, 16'd2, 16'd2));
    waitDone(0, 20, lat);
    applyStimulus(0, 1'b1, 1'b0, 16'h0040, 16'h0000, 1, mk(1'b0, 16'hA5A5, 16'd3, 16'd2));
    waitDone(0, 20, lat);

    // Upper address bits are ignored: 0x0802 aliases 0x0002.
    applyStimulus(0, 1'b0, 1'b1, 16'h0802, 16'hBEEF, 1, mk(1'b0, 16'hA5A5, 16'd3, 16'd3));
    waitDone(0, 20, lat);
    applyStimulus(0, 1'b1, 1'b0, 16'h0002, 16'h0000, 1, mk(1'b0, 16'hBEEF, 16'd4, 16'd3));
    waitDone(0, 20, lat);

    // Reset in the middle of a write aborts it.
    applyStimulus(0, 1'b0, 1'b1, 16'h0020, 16'h5555, 1, mk(1'b0, 16'hBEEF, 16'd4, 16'd4));
    waitDone(0, 20, lat);
    applyStimulus(0, 1'b0, 1'b1, 16'h0020, 16'h1111, 0, mk(1'b0, 16'h0, 16'h0, 16'h0));
    @(posedge clk);
    #1;
    rst4 = 1'b0;
    #1;
    checkOutput("abort done",     32'(done4),    32'h0);
    checkOutput("abort wr_count", 32'(wrCount4), 32'h0);
    checkOutput("abort rd_count", 32'(rdCount4), 32'h0);
    checkOutput("abort data_out", 32'(dataOut4), 32'h0);
    repeat (2) @(posedge clk);
    #1;
    rst4 = 1'b1;
    doneSeen = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (done4 === 1'b1) doneSeen++;
    end
    checkOutput("abort no done pulse", 32'(doneSeen), 32'd0);
    applyStimulus(0, 1'b1, 1'b0, 16'h0020, 16'h0000, 1, mk(1'b0, 16'h5555, 16'd1, 16'd0));
    waitDone(0, 20, lat);

    // LATENCY=1: done on the cycle after acceptance, then saturate wr_count.
    applyStimulus(1, 1'b0, 1'b1, 16'h0004, 16'h0101, 1, mk(1'b0, 16'h0000, 16'd0, 16'd1));
    waitDone(1, 10, lat);
    checkOutput("dut1 latency", 32'(lat), 32'd1);
    reqWr1 = 1'b1; addr1 = 16'h0004; dataIn1 = 16'h0101;
    for (int k = 2; k <= 65536; k++) begin
      q1.push_back(mk(1'b0, 16'h0000, 16'd0, (k > 65535) ? 16'hFFFF : 16'(k)));
      @(posedge clk);
      #1;
    end
    addr1 = 16'h0006; dataIn1 = 16'h7E57;
    q1.push_back(mk(1'b0, 16'h0000, 16'd0, 16'hFFFF));
    @(posedge clk);
    #1;
    reqWr1 = 1'b0; reqRd1 = 1'b1;
    q1.push_back(mk(1'b0, 16'h7E57, 16'd1, 16'hFFFF));
    @(posedge clk);
    #1;
    reqRd1 = 1'b0;
    @(negedge clk);
    checkOutput("dut1 wr_count saturated", 32'(wrCount1), 32'hFFFF);
    checkOutput("dut1 read after write",   32'(dataOut1), 32'h7E57);
    repeat (3) @(negedge clk);

    checkOutput("dut4 scoreboard drained", 32'(q4.size()), 32'd0);
    checkOutput("dut1 scoreboard drained", 32'(q1.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
    $finish;
  end

endmodule
